multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 45 ++++
 rtl/multicycle_control_if.sv | 33 +++
 rtl/multicycle_control_mem_wait_timer.sv | 38 +++
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU operation classes
// and FSM state codes (the ALUOp codes are also consumed by the ALU control decoder).
package multicycle_control_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [2:0] {
        ALU_NONE  = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_ADD   = 3'b100,
        ALU_OR    = 3'b101,
        ALU_LUI   = 3'b110,
        ALU_RTYPE = 3'b111
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_WB_R   = 4'd7,
        S_EXEC_I = 4'd8,
        S_WB_I   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_e;

    // States that stall on MemReady and therefore count toward the timeout.
    function automatic logic is_mem_wait(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath-facing signal bundle of the multicycle controller.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic [2:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic [3:0] State;
    logic       IllegalOp;
    logic       MemError;

    modport master (
        output Opcode, Zero, MemReady,
        input  ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, PCWrite, PCSource, State, IllegalOp, MemError
    );

    modport slave (
        input  Opcode, Zero, MemReady,
        output ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, PCWrite, PCSource, State, IllegalOp, MemError
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags the cycle in which the
// MEM_TIMEOUT-th stall occurs.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_active_i,
    input  logic mem_ready_i,
    input  logic state_change_i,
    output logic timeout_o
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_change_i || mem_ready_i || !wait_active_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Completion in the last allowed cycle wins over the timeout.
    assign timeout_o = wait_active_i && !mem_ready_i && (cnt_q == LAST);
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: Moore-decoded datapath strobes, memory
// wait timeout and sticky fault flags.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);
    state_e  state_q, state_d, cur_state;
    logic    illegal_q, illegal_d;
    logic    mem_err_q, mem_err_d;
    logic    timeout;

    alu_op_e alu_op;
    logic    src_a, iord, mem_read, mem_write, ir_write, reg_write;
    logic    reg_dst, mem_to_reg, pc_write;
    logic [1:0] src_b, pc_source;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk            (clk),
        .reset          (reset),
        .wait_active_i  (is_mem_wait(state_q)),
        .mem_ready_i    (bus.MemReady),
        .state_change_i (state_d != state_q),
        .timeout_o      (timeout)
    );

    // NOTE: every comb output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        case (state_q)
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (bus.MemReady) begin
                    state_d = (state_q == S_FETCH) ? S_DECODE :
                              (state_q == S_MEMRD) ? S_MEMWB  : S_FETCH;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW:            state_d = S_MEMADR;
                    OP_R:                    state_d = S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    OP_J:                    state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    // While reset is held the outputs already present the FETCH decode.
    assign cur_state = reset ? S_FETCH : state_q;

    always_comb begin
        alu_op     = ALU_NONE;
        src_a      = 1'b0;
        src_b      = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        case (cur_state)
            S_FETCH: begin
                mem_read = 1'b1;
                src_b    = 2'b01;
                alu_op   = ALU_ADD;
                ir_write = bus.MemReady;
                pc_write = bus.MemReady;
            end
            S_DECODE: begin
                src_b  = 2'b11;
                alu_op = ALU_ADD;
            end
            S_MEMADR: begin
                src_a  = 1'b1;
                src_b  = 2'b10;
                alu_op = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC_R: begin
                src_a  = 1'b1;
                alu_op = ALU_RTYPE;
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_EXEC_I: begin
                src_a  = 1'b1;
                src_b  = 2'b10;
                alu_op = (bus.Opcode == OP_ORI) ? ALU_OR :
                         (bus.Opcode == OP_LUI) ? ALU_LUI : ALU_ADD;
            end
            S_WB_I: reg_write = 1'b1;
            S_BRANCH: begin
                src_a     = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                pc_write  = (bus.Opcode == OP_BNE) ? !bus.Zero : bus.Zero;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ALUOp     = alu_op;
    assign bus.ALUSrcA   = src_a;
    assign bus.ALUSrcB   = src_b;
    assign bus.IorD      = iord;
    assign bus.MemRead   = mem_read;
    assign bus.MemWrite  = mem_write;
    assign bus.IRWrite   = ir_write;
    assign bus.RegWrite  = reg_write;
    assign bus.RegDst    = reg_dst;
    assign bus.MemtoReg  = mem_to_reg;
    assign bus.PCWrite   = pc_write;
    assign bus.PCSource  = pc_source;
    assign bus.State     = cur_state;
    assign bus.IllegalOp = illegal_q;
    assign bus.MemError  = mem_err_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction route model with memory-stall counting,
// directed scenarios with literal expectations, then randomized traffic.
module tb_multicycle_control;
    localparam int TMO = 16;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4;
    localparam int ST_MEMWR = 5, ST_EXEC_R = 6, ST_WB_R = 7, ST_EXEC_I = 8, ST_WB_I = 9;
    localparam int ST_BRANCH = 10, ST_JUMP = 11, ST_HALT = 15;

    localparam logic [5:0] R = 6'o00, ADDI = 6'o10, ORI = 6'o15, LUI = 6'o17;
    localparam logic [5:0] LW = 6'o43, SW = 6'o53, BEQ = 6'o04, BNE = 6'o05, J = 6'o02;

    logic clk = 1'b0;
    logic reset;
    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: current state, queue of states still to visit for this instruction,
    // consecutive stalled cycles, sticky flags.
    int   m_state = ST_FETCH;
    int   m_route[$];
    int   m_stall = 0;
    bit   m_ill = 1'b0, m_merr = 1'b0, m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected output word {State, ALUOp, SrcA, SrcB, IorD, MemRead, MemWrite,
    // IRWrite, RegWrite, RegDst, MemtoReg, PCWrite, PCSource} for one state.
    function automatic logic [19:0] exp_out(int st, logic [5:0] op, logic mr, logic z);
        logic [2:0] aop = 3'b000;
        logic       sa = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, rd = 0, m2r = 0, pcw = 0;
        logic [1:0] sb = 2'b00, pcs = 2'b00;
        case (st)
            ST_FETCH:  begin mrd = 1; sb = 2'b01; aop = 3'b100; irw = mr; pcw = mr; end
            ST_DECODE: begin sb = 2'b11; aop = 3'b100; end
            ST_MEMADR: begin sa = 1; sb = 2'b10; aop = 3'b100; end
            ST_MEMRD:  begin mrd = 1; iord = 1; end
            ST_MEMWB:  begin rw = 1; m2r = 1; end
            ST_MEMWR:  begin mwr = 1; iord = 1; end
            ST_EXEC_R: begin sa = 1; aop = 3'b111; end
            ST_WB_R:   begin rd = 1; rw = 1; end
            ST_EXEC_I: begin sa = 1; sb = 2'b10; aop = (op == ORI) ? 3'b101 : (op == LUI) ? 3'b110 : 3'b100; end
            ST_WB_I:   rw = 1;
            ST_BRANCH: begin sa = 1; aop = 3'b001; pcs = 2'b01; pcw = (op == BEQ) ? z : !z; end
            ST_JUMP:   begin pcs = 2'b10; pcw = 1; end
            default:   ;
        endcase
        return {4'(st), aop, sa, sb, iord, mrd, mwr, irw, rw, rd, m2r, pcw, pcs};
    endfunction

    task automatic model_step();
        if (reset) begin
            m_valid = 1'b1; m_state = ST_FETCH; m_stall = 0;
            m_ill = 1'b0; m_merr = 1'b0; m_route.delete();
        end else if (m_state == ST_HALT) begin
            m_state = ST_HALT;
        end else if ((m_state == ST_FETCH || m_state == ST_MEMRD || m_state == ST_MEMWR) && !bus.MemReady) begin
            m_stall++;
            if (m_stall == TMO) begin m_state = ST_HALT; m_merr = 1'b1; end
        end else begin
            m_stall = 0;
            if (m_state == ST_FETCH) m_state = ST_DECODE;
            else begin
                if (m_state == ST_DECODE) begin
                    case (bus.Opcode)
                        LW:             m_route = '{ST_MEMADR, ST_MEMRD, ST_MEMWB};
                        SW:             m_route = '{ST_MEMADR, ST_MEMWR};
                        R:              m_route = '{ST_EXEC_R, ST_WB_R};
                        ADDI, ORI, LUI: m_route = '{ST_EXEC_I, ST_WB_I};
                        BEQ, BNE:       m_route = '{ST_BRANCH};
                        J:              m_route = '{ST_JUMP};
                        default: begin m_route.delete(); m_ill = 1'b1; end
                    endcase
                end
                m_state = (m_route.size() > 0) ? m_route.pop_front() : ST_FETCH;
            end
        end
    endtask

    task automatic compare_cycle();
        logic [19:0] act;
        if (!m_valid) return;
        act = {bus.State, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.IorD, bus.MemRead, bus.MemWrite,
               bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.PCWrite, bus.PCSource};
        check("outputs", 32'(act), 32'(exp_out(reset ? ST_FETCH : m_state, bus.Opcode, bus.MemReady, bus.Zero)));
        if (!reset) check("flags", {30'd0, bus.IllegalOp, bus.MemError}, {30'd0, m_ill, m_merr});
    endtask

    // One cycle: compare on the falling edge, advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [5:0] op_pool [11];

    initial begin
        op_pool = '{R, ADDI, ORI, LUI, LW, SW, BEQ, BNE, J, 6'o77, 6'o21};
        reset = 1'b1; bus.MemReady = 1'b1; bus.Zero = 1'b0; bus.Opcode = R;
        #2;
        check("rst_memread", 32'(bus.MemRead), 1);
        check("rst_alusrcb", 32'(bus.ALUSrcB), 1);
        check("rst_aluop", 32'(bus.ALUOp), 3'b100);
        check("rst_irwrite", 32'(bus.IRWrite), 1);
        bus.MemReady = 1'b0; #1;
        check("rst_pcwrite_low", 32'(bus.PCWrite), 0);
        bus.MemReady = 1'b1;
        tick();
        check("post_rst_state", 32'(bus.State), ST_FETCH);
        check("post_rst_flags", {30'd0, bus.IllegalOp, bus.MemError}, 0);
        reset = 1'b0;

        // R-type: 0,1,6,7,0
        tick(); check("r_decode", 32'(bus.State), 1);
        tick(); check("r_exec", 32'(bus.State), 6); check("r_aluop", 32'(bus.ALUOp), 3'b111);
        tick(); check("r_wb", 32'(bus.State), 7);
        check("r_wb_strobes", {30'd0, bus.RegDst, bus.RegWrite}, 3);
        tick(); check("r_back", 32'(bus.State), 0);

        // LW with three stalled MEMRD cycles: 8 cycles total
        bus.Opcode = LW;
        ticks(2); check("lw_memadr", 32'(bus.State), 2);
        bus.MemReady = 1'b0;
        ticks(4); check("lw_memrd_held", 32'(bus.State), 3);
        bus.MemReady = 1'b1;
        tick(); check("lw_memwb", 32'(bus.State), 4); check("lw_memtoreg", 32'(bus.MemtoReg), 1);
        tick(); check("lw_back_after_8", 32'(bus.State), 0);

        // BEQ then BNE with Zero=1
        bus.Zero = 1'b1; bus.Opcode = BEQ;
        ticks(2); check("beq_state", 32'(bus.State), 10);
        check("beq_pc", {30'd0, bus.PCWrite, 1'b0} | 32'(bus.PCSource), 3);
        tick(); bus.Opcode = BNE;
        ticks(2); check("bne_state", 32'(bus.State), 10);
        check("bne_pcwrite", 32'(bus.PCWrite), 0); check("bne_pcsource", 32'(bus.PCSource), 1);
        tick(); bus.Zero = 1'b0;

        // Illegal opcode, then ADDI
        bus.Opcode = 6'o77;
        tick(); check("ill_decode_flag", 32'(bus.IllegalOp), 0);
        tick(); check("ill_to_fetch", 32'(bus.State), 0); check("ill_flag", 32'(bus.IllegalOp), 1);
        bus.Opcode = ADDI;
        ticks(2); check("addi_exec", 32'(bus.State), 8); check("addi_aluop", 32'(bus.ALUOp), 3'b100);
        ticks(2); check("ill_sticky", 32'(bus.IllegalOp), 1);

        // FETCH timeout and last-cycle completion
        bus.Opcode = R; bus.MemReady = 1'b0;
        ticks(TMO - 1); check("tmo_not_yet", 32'(bus.State), 0);
        tick(); check("tmo_halt", 32'(bus.State), 15); check("tmo_merr", 32'(bus.MemError), 1);
        check("halt_memread", 32'(bus.MemRead), 0);
        bus.MemReady = 1'b1;
        ticks(3); check("halt_stays", 32'(bus.State), 15);
        reset = 1'b1; tick(); reset = 1'b0; bus.MemReady = 1'b0;
        ticks(TMO - 1); bus.MemReady = 1'b1;
        tick(); check("tmo_complete_wins", 32'(bus.State), 1); check("tmo_no_merr", 32'(bus.MemError), 0);
        ticks(3);

        // Reset in the middle of a MEMWR wait
        bus.Opcode = 6'o77; ticks(2);
        bus.Opcode = SW; ticks(2); bus.MemReady = 1'b0;
        ticks(3); check("sw_waiting", 32'(bus.State), 5);
        reset = 1'b1; tick(); reset = 1'b0;
        check("sw_rst_state", 32'(bus.State), 0);
        check("sw_rst_flags", {30'd0, bus.IllegalOp, bus.MemError}, 0);
        ticks(TMO - 1); check("sw_rst_cnt_clear", 32'(bus.State), 0);
        bus.MemReady = 1'b1; tick();

        // Randomized traffic
        for (int blk = 0; blk < 8; blk++) begin
            reset = 1'b1; tick(); reset = 1'b0;
            for (int c = 0; c < 100; c++) begin
                bus.MemReady = ($urandom_range(0, 9) < 7);
                bus.Zero = 1'($urandom_range(0, 1));
                if (m_state == ST_FETCH) bus.Opcode = op_pool[$urandom_range(0, 10)];
                reset = ($urandom_range(0, 63) == 0);
                tick();
            end
            reset = 1'b0; bus.MemReady = 1'b0;
            ticks(20);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
